// File: rtl/ifu_fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues single-cycle-latency word reads,
// and queues {pc, instr} pairs for decode behind a valid/ready handshake.
module ifu_fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          DEPTH    = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     redirect_valid,
    input  logic [31:0]              redirect_pc,
    output logic                     imem_req,
    output logic [31:0]              imem_addr,
    input  logic [31:0]              imem_rdata,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_pc,
    output logic [31:0]              out_instr,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_req_pc;
    logic          r_inflight;
    logic [CW-1:0] r_count;
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [31:0]   r_pc_q    [DEPTH];
    logic [31:0]   r_instr_q [DEPTH];

    logic [CW:0]   w_used;
    logic          w_req;
    logic          w_push;
    logic          w_pop;

    // Credits use registered state only, so a same-cycle pop never lets an extra request out.
    assign w_used = {1'b0, r_count} + {{CW{1'b0}}, r_inflight};
    assign w_req  = !reset && !redirect_valid && (w_used < DEPTH_C);
    assign w_push = r_inflight && !redirect_valid;
    assign w_pop  = out_valid && out_ready;

    assign imem_req  = w_req;
    assign imem_addr = reset ? RESET_PC : r_fetch_pc;
    assign out_valid = (r_count != '0);
    assign out_pc    = out_valid ? r_pc_q[r_rd_ptr]    : 32'h0;
    assign out_instr = out_valid ? r_instr_q[r_rd_ptr] : 32'h0;
    assign count     = r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_pc <= RESET_PC;
            r_inflight <= 1'b0;
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
        end else if (redirect_valid) begin
            // The response landing this cycle belongs to the old stream and is dropped.
            r_fetch_pc <= {redirect_pc[31:2], 2'b00};
            r_inflight <= 1'b0;
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
        end else begin
            r_inflight <= w_req;
            if (w_req)
                r_fetch_pc <= r_fetch_pc + 32'd4;
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_req)
            r_req_pc <= r_fetch_pc;
        if (w_push && !reset) begin
            r_pc_q[r_wr_ptr]    <= r_req_pc;
            r_instr_q[r_wr_ptr] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_ifu_fetch_queue.sv
// Bench for ifu_fetch_queue: cycle-level scoreboard plus a vector table and corner sequences.
module tb_ifu_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [2:0]  count;

    ifu_fetch_queue #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
        .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ready;
        logic        req;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] pc;
        logic [31:0] instr;
    } vec_t;

    vec_t tbl [6];

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_on = 1'b0;

    logic [63:0] m_q [$];
    logic        m_pend;
    logic [31:0] m_pend_pc;
    logic [31:0] m_fpc;

    logic        obs_req, obs_valid;
    logic [31:0] obs_addr, obs_pc, obs_instr;
    logic [2:0]  obs_count;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return 32'h1000 + ((a - 32'h3000) >> 2);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        logic        exp_req;
        logic        cap_req;
        logic [31:0] cap_addr;
        #1;
        obs_req   = imem_req;
        obs_addr  = imem_addr;
        obs_valid = out_valid;
        obs_pc    = out_pc;
        obs_instr = out_instr;
        obs_count = count;
        if (chk_on) begin
            exp_req = !reset && !redirect_valid && ((m_q.size() + int'(m_pend)) < DEPTH);
            chk("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
            chk("imem_addr", imem_addr, reset ? RESET_PC : m_fpc);
            chk("count", {29'b0, count}, m_q.size());
            chk("out_valid", {31'b0, out_valid}, {31'b0, m_q.size() != 0});
            if (m_q.size() != 0) begin
                chk("out_pc", out_pc, m_q[0][63:32]);
                chk("out_instr", out_instr, m_q[0][31:0]);
            end else begin
                chk("out_pc_idle", out_pc, 32'h0);
                chk("out_instr_idle", out_instr, 32'h0);
            end
        end
        cap_req  = imem_req;
        cap_addr = imem_addr;
        if (reset) begin
            m_q.delete();
            m_pend = 1'b0;
            m_fpc  = RESET_PC;
        end else begin
            exp_req = !redirect_valid && ((m_q.size() + int'(m_pend)) < DEPTH);
            if (out_ready && m_q.size() != 0)
                void'(m_q.pop_front());
            if (redirect_valid) begin
                m_q.delete();
                m_pend = 1'b0;
                m_fpc  = {redirect_pc[31:2], 2'b00};
            end else begin
                if (m_pend)
                    m_q.push_back({m_pend_pc, mem_f(m_pend_pc)});
                m_pend = exp_req;
                if (exp_req) begin
                    m_pend_pc = m_fpc;
                    m_fpc     = m_fpc + 32'd4;
                end
            end
        end
        @(posedge clk);
        #1;
        imem_rdata = cap_req ? mem_f(cap_addr) : 32'hDEAD_BEEF;
        chk_on = 1'b1;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        redirect_valid = 1'b0;
        repeat (n) tick();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nreq;
        for (int k = 0; k < 6; k++) begin
            tbl[k].ready = 1'b1;
            tbl[k].req   = 1'b1;
            tbl[k].addr  = 32'h3000 + 32'(4 * k);
            tbl[k].vld   = (k >= 2);
            tbl[k].pc    = (k >= 2) ? 32'h3000 + 32'(4 * (k - 2)) : 32'h0;
            tbl[k].instr = (k >= 2) ? 32'h1000 + 32'(k - 2) : 32'h0;
        end

        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
        imem_rdata = 32'h0; out_ready = 1'b0;
        m_pend = 1'b0; m_pend_pc = 32'h0; m_fpc = RESET_PC;

        // Reset state and streaming vectors
        do_reset(2);
        chk("rst_count", {29'b0, obs_count}, 32'h0);
        chk("rst_valid", {31'b0, obs_valid}, 32'h0);
        chk("rst_req", {31'b0, obs_req}, 32'h0);
        chk("rst_addr", obs_addr, RESET_PC);
        for (int k = 0; k < 6; k++) begin
            out_ready = tbl[k].ready;
            tick();
            chk($sformatf("t1_req[%0d]", k), {31'b0, obs_req}, {31'b0, tbl[k].req});
            chk($sformatf("t1_addr[%0d]", k), obs_addr, tbl[k].addr);
            chk($sformatf("t1_vld[%0d]", k), {31'b0, obs_valid}, {31'b0, tbl[k].vld});
            chk($sformatf("t1_pc[%0d]", k), obs_pc, tbl[k].pc);
            chk($sformatf("t1_instr[%0d]", k), obs_instr, tbl[k].instr);
        end
        repeat (4) tick();

        // Backpressure: fill to DEPTH, then drain
        out_ready = 1'b0;
        do_reset(1);
        nreq = 0;
        repeat (8) begin
            tick();
            nreq += int'(obs_req);
        end
        chk("t2_reqs", nreq, 4);
        chk("t2_count", {29'b0, obs_count}, 32'd4);
        out_ready = 1'b1;
        tick();
        chk("t2_no_req_on_pop", {31'b0, obs_req}, 32'h0);
        chk("t2_head", obs_pc, 32'h3000);
        tick();
        chk("t2_resume_req", {31'b0, obs_req}, 32'h1);
        chk("t2_resume_addr", obs_addr, 32'h3010);
        repeat (8) tick();

        // Redirect while a request is inflight
        do_reset(1);
        repeat (5) tick();
        redirect_valid = 1'b1; redirect_pc = 32'h3400;
        tick();
        redirect_valid = 1'b0;
        tick();
        chk("t3_count", {29'b0, obs_count}, 32'h0);
        chk("t3_valid", {31'b0, obs_valid}, 32'h0);
        chk("t3_addr", obs_addr, 32'h3400);
        tick(); tick();
        chk("t3_first_pc", obs_pc, 32'h3400);
        repeat (3) tick();

        // Back-to-back redirects, unaligned target
        redirect_valid = 1'b1; redirect_pc = 32'h3500;
        tick();
        redirect_pc = 32'h3403;
        tick();
        redirect_valid = 1'b0;
        tick();
        chk("t4_addr", obs_addr, 32'h3400);
        tick(); tick();
        chk("t4_pc", obs_pc, 32'h3400);
        repeat (3) tick();

        // Reset mid-stream with count=3 and one inflight
        out_ready = 1'b0;
        do_reset(1);
        repeat (4) tick();
        reset = 1'b1;
        tick();
        chk("t5_pre_count", {29'b0, obs_count}, 32'd3);
        reset = 1'b0; out_ready = 1'b1;
        tick();
        chk("t5_valid", {31'b0, obs_valid}, 32'h0);
        chk("t5_count", {29'b0, obs_count}, 32'h0);
        chk("t5_addr", obs_addr, 32'h3000);
        tick(); tick();
        chk("t5_first_pc", obs_pc, 32'h3000);
        repeat (3) tick();

        // Redirect and pop in the same cycle
        do_reset(1);
        repeat (4) tick();
        redirect_valid = 1'b1; redirect_pc = 32'h3800;
        tick();
        chk("t6_pop_valid", {31'b0, obs_valid}, 32'h1);
        chk("t6_pop_pc", obs_pc, 32'h3008);
        redirect_valid = 1'b0;
        tick();
        chk("t6_count", {29'b0, obs_count}, 32'h0);
        chk("t6_addr", obs_addr, 32'h3800);
        tick(); tick();
        chk("t6_next_pc", obs_pc, 32'h3800);
        repeat (4) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
